uart_board_dump: RTL and testbench

Formats the 3x3 tic-tac-toe board as ASCII text and feeds the bytes, one at a time, into the upstream side of the UART transmitter (uart_tx wr/din/ready). It latches a board snapshot on a start pulse and walks a fixed byte sequence. It handshakes each byte with the transmitter and signals completion once the last byte has fully left the serial line. Sits between the game-state logic and uart_tx.

---
 rtl/uart_board_dump_if.sv | 10 +
 rtl/uart_board_dump.sv | 173 +++++++++++++++++
 tb/tb_uart_board_dump.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_board_dump_if.sv
// Byte handshake between uart_board_dump and the uart_tx upstream port.
// master = board dumper (drives wr/din), slave = transmitter (drives ready).
interface uart_board_dump_if;
  logic       tx_wr;
  logic [7:0] tx_din;
  logic       tx_ready;

  modport master (output tx_wr, output tx_din, input tx_ready);
  modport slave  (input tx_wr, input tx_din, output tx_ready);
endinterface

// File: rtl/uart_board_dump.sv
// Streams a 3x3 tic-tac-toe board as ASCII text into uart_tx, one byte per handshake.
// Optional feature: define BOARD_DUMP_ANSI_EN to prefix the dump with ESC[2J ESC[H.
module uart_board_dump #(
  parameter logic [7:0] EMPTY_CHAR = 8'h2E,
  parameter logic [7:0] X_CHAR     = 8'h58,
  parameter logic [7:0] O_CHAR     = 8'h4F
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [17:0]               board,
  output logic                      busy,
  output logic                      done,
  uart_board_dump_if.master         tx
);

`ifdef BOARD_DUMP_ANSI_EN
  localparam logic [5:0] LAST_IDX = 6'd41;
`else
  localparam logic [5:0] LAST_IDX = 6'd34;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT} state_t;

  state_t      state_r, state_s;
  logic [5:0]  idx_r, idx_s;
  logic [17:0] snap_r, snap_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        wr_r, wr_s;
  logic [7:0]  din_r, din_s;
  logic [7:0]  byte_s;

  function automatic logic [7:0] cell_char(input logic [1:0] code);
    logic [7:0] ch;
    case (code)
      2'b00:   ch = EMPTY_CHAR;
      2'b01:   ch = X_CHAR;
      2'b10:   ch = O_CHAR;
      default: ch = 8'h3F;
    endcase
    return ch;
  endfunction

  // Seven bytes per line: even lines are board rows, odd lines are separators.
  function automatic logic [7:0] text_byte(input logic [5:0] k, input logic [17:0] snap);
    logic [5:0] line_v;
    logic [5:0] col_v;
    logic [3:0] cell_v;
    logic [7:0] ch;
    line_v = k / 6'd7;
    col_v  = k % 6'd7;
    cell_v = 4'((line_v >> 1) * 6'd3 + (col_v >> 1));
    case (col_v)
      6'd5:        ch = 8'h0D;
      6'd6:        ch = 8'h0A;
      6'd1, 6'd3:  ch = line_v[0] ? 8'h2B : 8'h7C;
      default:     ch = line_v[0] ? 8'h2D : cell_char(snap[{cell_v, 1'b0} +: 2]);
    endcase
    return ch;
  endfunction

`ifdef BOARD_DUMP_ANSI_EN
  function automatic logic [7:0] ansi_byte(input logic [2:0] k);
    logic [7:0] ch;
    case (k)
      3'd0:    ch = 8'h1B;
      3'd1:    ch = 8'h5B;
      3'd2:    ch = 8'h32;
      3'd3:    ch = 8'h4A;
      3'd4:    ch = 8'h1B;
      3'd5:    ch = 8'h5B;
      3'd6:    ch = 8'h48;
      default: ch = 8'h00;
    endcase
    return ch;
  endfunction
`endif

  // Byte selected by the current index and the latched snapshot.
  always_comb begin
`ifdef BOARD_DUMP_ANSI_EN
    if (idx_r < 6'd7) begin
      byte_s = ansi_byte(idx_r[2:0]);
    end else begin
      byte_s = text_byte(idx_r - 6'd7, snap_r);
    end
`else
    byte_s = text_byte(idx_r, snap_r);
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    snap_s  = snap_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    wr_s    = 1'b0;
    din_s   = din_r;
    case (state_r)
      IDLE: begin
        // A start landing on the done pulse is dropped.
        if (start && !done_r) begin
          snap_s  = board;
          idx_s   = 6'd0;
          busy_s  = 1'b1;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (tx.tx_ready) begin
          wr_s    = 1'b1;
          din_s   = byte_s;
          state_s = HOLD;
        end else begin
          state_s = ISSUE;
        end
      end
      HOLD: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (tx.tx_ready) begin
          if (idx_r == LAST_IDX) begin
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = IDLE;
          end else begin
            idx_s   = idx_r + 6'd1;
            state_s = ISSUE;
          end
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= 6'd0;
      snap_r  <= 18'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      wr_r    <= 1'b0;
      din_r   <= 8'h00;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      snap_r  <= snap_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      wr_r    <= wr_s;
      din_r   <= din_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign tx.tx_wr  = wr_r;
  assign tx.tx_din = din_r;

endmodule

// File: tb/tb_uart_board_dump.sv
// Directed bench for uart_board_dump with a uart_tx ready model (16 clocks/bit, 10-bit frame).
module tb_uart_board_dump;

`ifdef BOARD_DUMP_ANSI_EN
  localparam int PRE = 7;
`else
  localparam int PRE = 0;
`endif
  localparam int NBYTES = PRE + 35;
  localparam int FRAME  = 160;
  localparam int LIMIT  = 20000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [17:0] board = 18'd0;
  logic        busy, done;
  logic        hold_low = 1'b0;

  uart_board_dump_if tx_if();

  uart_board_dump dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .board (board),
    .busy  (busy),
    .done  (done),
    .tx    (tx_if)
  );

  always #5 clk = ~clk;

  int unsigned frame_cnt = 0;
  assign tx_if.tx_ready = (frame_cnt == 0) && !tx_if.tx_wr && !hold_low;

  // Transmitter busy for one frame after each accepted strobe.
  always @(posedge clk) begin
    if (tx_if.tx_wr) frame_cnt <= FRAME;
    else if (frame_cnt != 0) frame_cnt <= frame_cnt - 1;
  end

  logic [7:0] cap[$];
  int done_cnt = 0;
  int wr_long  = 0;
  logic wr_prev = 1'b0;

  always @(posedge clk) begin
    if (tx_if.tx_wr) cap.push_back(tx_if.tx_din);
    if (tx_if.tx_wr && wr_prev) wr_long <= wr_long + 1;
    wr_prev <= tx_if.tx_wr;
    if (done) done_cnt <= done_cnt + 1;
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic [7:0] exp_bytes[NBYTES];

  function automatic logic [7:0] ch_of(input logic [17:0] b, input int i);
    logic [1:0] c;
    c = b[2*i +: 2];
    if (c == 2'b00) return 8'h2E;
    else if (c == 2'b01) return 8'h58;
    else if (c == 2'b10) return 8'h4F;
    else return 8'h3F;
  endfunction

  task automatic build_exp(input logic [17:0] b);
    int n;
    n = 0;
`ifdef BOARD_DUMP_ANSI_EN
    exp_bytes[0] = 8'h1B; exp_bytes[1] = 8'h5B; exp_bytes[2] = 8'h32; exp_bytes[3] = 8'h4A;
    exp_bytes[4] = 8'h1B; exp_bytes[5] = 8'h5B; exp_bytes[6] = 8'h48;
    n = 7;
`endif
    for (int r = 0; r < 3; r++) begin
      exp_bytes[n]   = ch_of(b, 3*r);
      exp_bytes[n+1] = 8'h7C;
      exp_bytes[n+2] = ch_of(b, 3*r+1);
      exp_bytes[n+3] = 8'h7C;
      exp_bytes[n+4] = ch_of(b, 3*r+2);
      exp_bytes[n+5] = 8'h0D;
      exp_bytes[n+6] = 8'h0A;
      n += 7;
      if (r < 2) begin
        exp_bytes[n]   = 8'h2D; exp_bytes[n+1] = 8'h2B; exp_bytes[n+2] = 8'h2D;
        exp_bytes[n+3] = 8'h2B; exp_bytes[n+4] = 8'h2D; exp_bytes[n+5] = 8'h0D;
        exp_bytes[n+6] = 8'h0A;
        n += 7;
      end
    end
  endtask

  task automatic run_dump(input logic [17:0] b, input string name);
    @(negedge clk);
    board = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_rise"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done !== 1'b1 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (t >= LIMIT) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_busy_at_done"}, 32'(busy), 32'd0);
      @(negedge clk);
      check({name, "_done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  task automatic verify_dump(input string name, input int base, input int d0, input logic [17:0] b);
    int mism;
    build_exp(b);
    check({name, "_count"}, 32'(cap.size() - base), 32'(NBYTES));
    check({name, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    mism = 0;
    for (int k = 0; k < NBYTES; k++) begin
      if (base + k < cap.size()) begin
        if (cap[base + k] !== exp_bytes[k]) mism++;
      end
    end
    check({name, "_content"}, 32'(mism), 32'd0);
  endtask

  typedef struct {
    logic [17:0] board;
    int          k;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int base, d0, viol, t;

    vecs[0]  = '{18'h00000, 0,  8'h2E};
    vecs[1]  = '{18'h00000, 1,  8'h7C};
    vecs[2]  = '{18'h00000, 5,  8'h0D};
    vecs[3]  = '{18'h00000, 6,  8'h0A};
    vecs[4]  = '{18'h00000, 7,  8'h2D};
    vecs[5]  = '{18'h00000, 8,  8'h2B};
    vecs[6]  = '{18'h00000, 34, 8'h0A};
    vecs[7]  = '{18'h30201, 0,  8'h58};
    vecs[8]  = '{18'h30201, 16, 8'h4F};
    vecs[9]  = '{18'h30201, 32, 8'h3F};
    vecs[10] = '{18'h30201, 2,  8'h2E};
    vecs[11] = '{18'h01020, 4,  8'h4F};
    vecs[12] = '{18'h01020, 28, 8'h58};
    vecs[13] = '{18'h01020, 30, 8'h2E};

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tx_wr", 32'(tx_if.tx_wr), 32'd0);
    check("rst_tx_din", 32'(tx_if.tx_din), 32'h00);
    reset = 1'b0;
    @(negedge clk);

    base = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 0 || vecs[i].board != vecs[i-1].board) begin
        base = cap.size();
        d0 = done_cnt;
        run_dump(vecs[i].board, $sformatf("dump_%05h", vecs[i].board));
        wait_done($sformatf("dump_%05h", vecs[i].board));
        verify_dump($sformatf("dump_%05h", vecs[i].board), base, d0, vecs[i].board);
      end
      if (base + PRE + vecs[i].k < cap.size())
        check($sformatf("vec%0d_k%0d", i, vecs[i].k), 32'(cap[base + PRE + vecs[i].k]), 32'(vecs[i].exp));
      else
        check($sformatf("vec%0d_k%0d_missing", i, vecs[i].k), 32'hFFFF_FFFF, 32'(vecs[i].exp));
    end

    // Transmitter stalls for 200 cycles after start.
    hold_low = 1'b1;
    base = cap.size();
    d0 = done_cnt;
    run_dump(18'h00000, "stall");
    viol = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tx_if.tx_wr !== 1'b0 || busy !== 1'b1) viol++;
    end
    check("stall_hold", 32'(viol), 32'd0);
    hold_low = 1'b0;
    @(negedge clk);
    check("stall_release_wr", 32'(tx_if.tx_wr), 32'd1);
    @(negedge clk);
    check("stall_wr_one_cycle", 32'(tx_if.tx_wr), 32'd0);
    wait_done("stall");
    verify_dump("stall", base, d0, 18'h00000);

    // Second start mid-dump with a different board must be ignored.
    base = cap.size();
    d0 = done_cnt;
    run_dump(18'h30201, "restart");
    repeat (10) @(negedge clk);
    board = 18'h2AAAA;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("restart");
    verify_dump("restart", base, d0, 18'h30201);

    // Reset while byte 12 is being strobed.
    base = cap.size();
    run_dump(18'h01020, "abort");
    t = 0;
    while (!(tx_if.tx_wr === 1'b1 && cap.size() - base == 12) && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    check("abort_reach_byte12", 32'(t < LIMIT), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_tx_wr", 32'(tx_if.tx_wr), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (FRAME + 5) @(negedge clk);
    base = cap.size();
    d0 = done_cnt;
    run_dump(18'h01020, "after_reset");
    wait_done("after_reset");
    verify_dump("after_reset", base, d0, 18'h01020);

    check("strobe_width", 32'(wr_long), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
